mcu_wdog_ctrl: RTL and testbench

MCU_WDOG_CTRL -- requirements
Module: mcu_wdog_ctrl

---
 rtl/mcu_isa_pkg.sv | 32 +++
 rtl/mcu_wdog_ctrl_if.sv | 18 +
 rtl/mcu_csr_alu.sv | 25 ++
 rtl/mcu_wdog_ctrl.sv | 151 +++++++++++++++
 tb/tb_mcu_wdog_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mcu_isa_pkg.sv
// mcu_isa_pkg: shared ISA-level definitions for custom CSR owners.
//   - CSR addresses of the custom watchdog block
//   - csr_op_e: CSR instruction operation (none / write / set / clear)
//   - wdog_state_e: watchdog FSM encoding (also visible in CTRL[7:6])
//   - CTRL_* bit indices of CSR_CP_WDOG_CTRL
package mcu_isa_pkg;

  localparam logic [11:0] CSR_CP_WDOG      = 12'h7C2;
  localparam logic [11:0] CSR_CP_WDOG_CTRL = 12'h7C3;

  typedef enum logic [1:0] {
    CSR_NONE = 2'd0,
    CSR_W    = 2'd1,
    CSR_S    = 2'd2,
    CSR_C    = 2'd3
  } csr_op_e;

  typedef enum logic [1:0] {
    WD_DISABLED = 2'd0,
    WD_COUNTING = 2'd1,
    WD_EXPIRED  = 2'd2,
    WD_RST_REQ  = 2'd3
  } wdog_state_e;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_KICK     = 1;
  localparam int CTRL_IRQ_EN   = 2;
  localparam int CTRL_RST_EN   = 3;
  localparam int CTRL_IRQ_PEND = 4;
  localparam int CTRL_LOCK     = 5;

endpackage

// File: rtl/mcu_wdog_ctrl_if.sv
// mcu_wdog_ctrl_if: retiring-CSR-instruction bus between the core and a CSR owner.
//   csr_valid/csr_addr/csr_op/csr_wdata : core -> owner
//   csr_hit/csr_rdata                   : owner -> core (combinational)
interface mcu_wdog_ctrl_if;
  import mcu_isa_pkg::*;

  logic        csr_valid;
  logic [11:0] csr_addr;
  csr_op_e     csr_op;
  logic [31:0] csr_wdata;
  logic        csr_hit;
  logic [31:0] csr_rdata;

  modport master (output csr_valid, csr_addr, csr_op, csr_wdata,
                  input  csr_hit, csr_rdata);
  modport slave  (input  csr_valid, csr_addr, csr_op, csr_wdata,
                  output csr_hit, csr_rdata);
endinterface

// File: rtl/mcu_csr_alu.sv
// mcu_csr_alu: combinational CSR read-modify-write value.
//   i_old   : current CSR value
//   i_wdata : rs1 / zero-extended immediate
//   i_op    : csr_op_e
//   o_new   : value to commit (i_old for CSR_NONE)
module mcu_csr_alu
  import mcu_isa_pkg::*;
(
  input  logic [31:0] i_old,
  input  logic [31:0] i_wdata,
  input  csr_op_e     i_op,
  output logic [31:0] o_new
);

  always_comb begin
    o_new = i_old;
    case (i_op)
      CSR_W:   o_new = i_wdata;
      CSR_S:   o_new = i_old | i_wdata;
      CSR_C:   o_new = i_old & ~i_wdata;
      default: o_new = i_old;
    endcase
  end

endmodule

// File: rtl/mcu_wdog_ctrl.sv
// mcu_wdog_ctrl: CSR-mapped watchdog with interrupt and system reset request.
//   clk, rst_n   : clock, synchronous active-low reset
//   csr          : CSR bus (slave side); owns CSR_CP_WDOG and CSR_CP_WDOG_CTRL
//   dbg_halt     : freezes the countdown and expiry transitions
//   wdog_irq     : registered IRQ_PEND & IRQ_EN
//   wdog_rst_req : high for RST_PULSE cycles in RST_REQ
//   wdog_state   : current FSM state
module mcu_wdog_ctrl
  import mcu_isa_pkg::*;
#(
  parameter logic [31:0] DEFAULT_RELOAD = 32'h00FF_FFFF,
  parameter int          RST_PULSE      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  mcu_wdog_ctrl_if.slave   csr,
  input  logic             dbg_halt,
  output logic             wdog_irq,
  output logic             wdog_rst_req,
  output logic [1:0]       wdog_state
);

  localparam logic [7:0] PULSE_LAST = 8'(RST_PULSE - 1);

  wdog_state_e r_state;
  logic [31:0] r_count, r_reload;
  logic        r_en, r_irq_en, r_rst_en, r_irq_pend, r_lock;
  logic        r_irq, r_rst_req;
  logic [7:0]  r_pcnt;

  logic        w_hit_wdog, w_hit_ctrl, w_wr, w_wr_wdog, w_wr_ctrl, w_en_wr;
  logic        w_live, w_kick, w_disable, w_arm;
  logic [31:0] w_ctrl_rd, w_old, w_new;
  logic        w_unused;

  assign w_hit_wdog = (csr.csr_addr == CSR_CP_WDOG);
  assign w_hit_ctrl = (csr.csr_addr == CSR_CP_WDOG_CTRL);

  // KICK always reads back as 0
  assign w_ctrl_rd = {24'b0, r_state, r_lock, r_irq_pend, r_rst_en, r_irq_en, 1'b0, r_en};
  assign w_old     = w_hit_wdog ? r_count : (w_hit_ctrl ? w_ctrl_rd : 32'b0);

  assign csr.csr_hit   = w_hit_wdog | w_hit_ctrl;
  assign csr.csr_rdata = w_old;

  mcu_csr_alu u_alu (
    .i_old   (w_old),
    .i_wdata (csr.csr_wdata),
    .i_op    (csr.csr_op),
    .o_new   (w_new)
  );

  assign w_wr      = csr.csr_valid & csr.csr_hit & (csr.csr_op != CSR_NONE);
  assign w_wr_wdog = w_wr & w_hit_wdog & ~r_lock;
  assign w_wr_ctrl = w_wr & w_hit_ctrl;
  assign w_en_wr   = w_wr_ctrl & ~r_lock;
  assign w_live    = (r_state == WD_COUNTING) | (r_state == WD_EXPIRED);
  assign w_kick    = w_wr_ctrl & w_new[CTRL_KICK] & w_live;
  assign w_disable = w_en_wr & ~w_new[CTRL_EN] & w_live;
  assign w_arm     = w_en_wr & w_new[CTRL_EN] & (r_state == WD_DISABLED);

  // read-only fields of the written value are intentionally dropped
  assign w_unused  = ^{w_new[31:6], w_new[CTRL_IRQ_PEND]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= WD_DISABLED;
      r_count    <= DEFAULT_RELOAD;
      r_reload   <= DEFAULT_RELOAD;
      r_en       <= 1'b0;
      r_irq_en   <= 1'b0;
      r_rst_en   <= 1'b0;
      r_irq_pend <= 1'b0;
      r_lock     <= 1'b0;
      r_irq      <= 1'b0;
      r_rst_req  <= 1'b0;
      r_pcnt     <= 8'd0;
    end else begin
      r_irq <= r_irq_pend & r_irq_en;

      if (w_wr_ctrl) begin
        r_irq_en <= w_new[CTRL_IRQ_EN];
        // LOCK is 0 here, so taking new[5] is set-only
        if (!r_lock) begin
          r_rst_en <= w_new[CTRL_RST_EN];
          r_lock   <= w_new[CTRL_LOCK];
        end
      end

      if (w_wr_wdog) r_reload <= w_new;

      case (r_state)
        WD_DISABLED: begin
          if (w_arm) begin
            r_state <= WD_COUNTING;
            r_en    <= 1'b1;
            r_count <= r_reload;
          end else if (w_wr_wdog) begin
            r_count <= w_new;
          end
        end
        WD_COUNTING, WD_EXPIRED: begin
          // software writes win over the countdown and any expiry
          if (w_disable) begin
            r_state    <= WD_DISABLED;
            r_en       <= 1'b0;
            r_irq_pend <= 1'b0;
          end else if (w_kick) begin
            r_state    <= WD_COUNTING;
            r_count    <= r_reload;
            r_irq_pend <= 1'b0;
          end else if (w_wr_wdog) begin
            r_count <= w_new;
          end else if (!dbg_halt) begin
            if (r_count != 32'd0) begin
              r_count <= r_count - 32'd1;
            end else if (r_state == WD_COUNTING) begin
              r_state    <= WD_EXPIRED;
              r_irq_pend <= 1'b1;
              r_count    <= r_reload;
            end else if (r_rst_en) begin
              r_state   <= WD_RST_REQ;
              r_rst_req <= 1'b1;
              r_pcnt    <= 8'd0;
            end else begin
              r_count <= r_reload;
            end
          end
        end
        WD_RST_REQ: begin
          if (w_wr_wdog) r_count <= w_new;
          if (r_pcnt == PULSE_LAST) begin
            r_state    <= WD_DISABLED;
            r_en       <= 1'b0;
            r_irq_pend <= 1'b0;
            r_rst_req  <= 1'b0;
            r_pcnt     <= 8'd0;
          end else begin
            r_pcnt <= r_pcnt + 8'd1;
          end
        end
        default: r_state <= WD_DISABLED;
      endcase
    end
  end

  assign wdog_irq     = r_irq;
  assign wdog_rst_req = r_rst_req;
  assign wdog_state   = r_state;

endmodule

// File: tb/tb_mcu_wdog_ctrl.sv
// tb_mcu_wdog_ctrl: directed self-checking bench for mcu_wdog_ctrl.
// Inputs change away from the rising edge; outputs are sampled 1 time unit
// after it. Each CSR access commits on the first rising edge after the call.
module tb_mcu_wdog_ctrl;
  import mcu_isa_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic dbg_halt;
  logic wdog_irq, wdog_rst_req;
  logic [1:0] wdog_state;
  int total = 0;
  int bad   = 0;
  int n;
  logic [31:0] r;

  mcu_wdog_ctrl_if bus();

  mcu_wdog_ctrl #(.DEFAULT_RELOAD(32'h00FF_FFFF), .RST_PULSE(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .csr          (bus),
    .dbg_halt     (dbg_halt),
    .wdog_irq     (wdog_irq),
    .wdog_rst_req (wdog_rst_req),
    .wdog_state   (wdog_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic csr_op(input csr_op_e op, input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.csr_valid = 1'b1;
    bus.csr_addr  = a;
    bus.csr_op    = op;
    bus.csr_wdata = d;
    @(posedge clk); #1;
    bus.csr_valid = 1'b0;
    bus.csr_op    = CSR_NONE;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    bus.csr_valid = 1'b0;
    bus.csr_op    = CSR_NONE;
    bus.csr_addr  = a;
    #1;
    d = bus.csr_rdata;
  endtask

  initial begin
    rst_n = 1'b0; dbg_halt = 1'b0;
    bus.csr_valid = 1'b0; bus.csr_addr = 12'h0; bus.csr_op = CSR_NONE; bus.csr_wdata = 32'h0;

    // reset state
    repeat (2) step();
    chk("rst_state", 32'(wdog_state), 32'd0);
    chk("rst_irq",   32'(wdog_irq), 32'd0);
    chk("rst_rreq",  32'(wdog_rst_req), 32'd0);
    rst_n = 1'b1;
    step();
    rd(CSR_CP_WDOG, r);      chk("rst_count", r, 32'h00FF_FFFF);
    rd(CSR_CP_WDOG_CTRL, r); chk("rst_ctrl", r, 32'h0);
    chk("hit_ctrl", 32'(bus.csr_hit), 32'd1);
    bus.csr_addr = 12'h123; #1;
    chk("miss_hit",   32'(bus.csr_hit), 32'd0);
    chk("miss_rdata", bus.csr_rdata, 32'h0);
    step();

    // basic countdown and first expiry, IRQ masked
    csr_op(CSR_W, CSR_CP_WDOG, 32'd10);
    rd(CSR_CP_WDOG, r); chk("t37_count", r, 32'd10);
    csr_op(CSR_S, CSR_CP_WDOG_CTRL, 32'h1);
    chk("t37_arm", 32'(wdog_state), 32'd1);
    repeat (10) step();
    chk("t37_state_c10", 32'(wdog_state), 32'd1);
    rd(CSR_CP_WDOG, r); chk("t37_count0", r, 32'd0);
    step();
    chk("t37_expired", 32'(wdog_state), 32'd2);
    rd(CSR_CP_WDOG_CTRL, r); chk("t37_pend", 32'(r[4]), 32'd1);
    chk("t37_irq_masked", 32'(wdog_irq), 32'd0);
    step();
    chk("t37_irq_masked2", 32'(wdog_irq), 32'd0);
    csr_op(CSR_C, CSR_CP_WDOG_CTRL, 32'h1);
    chk("t37_disable", 32'(wdog_state), 32'd0);
    rd(CSR_CP_WDOG_CTRL, r); chk("t37_ctrl_clr", r, 32'h0);

    // expiry -> IRQ, second expiry -> reset pulse
    csr_op(CSR_W, CSR_CP_WDOG, 32'd5);
    csr_op(CSR_W, CSR_CP_WDOG_CTRL, 32'hD);
    chk("t38_arm", 32'(wdog_state), 32'd1);
    repeat (6) step();
    chk("t38_exp1", 32'(wdog_state), 32'd2);
    step();
    chk("t38_irq", 32'(wdog_irq), 32'd1);
    repeat (5) step();
    chk("t38_rstreq_state", 32'(wdog_state), 32'd3);
    chk("t38_rstreq", 32'(wdog_rst_req), 32'd1);
    n = 0;
    while (wdog_rst_req && n < 100) begin
      n++;
      step();
    end
    chk("t38_pulse_len", 32'(n), 32'd16);
    chk("t38_after_state", 32'(wdog_state), 32'd0);
    rd(CSR_CP_WDOG_CTRL, r); chk("t38_en_clr", 32'(r[0]), 32'd0);

    // kick on the exact cycle count reaches 0
    csr_op(CSR_W, CSR_CP_WDOG, 32'd8);
    csr_op(CSR_W, CSR_CP_WDOG_CTRL, 32'h1);
    chk("t39_arm", 32'(wdog_state), 32'd1);
    repeat (8) step();
    rd(CSR_CP_WDOG, r); chk("t39_count0", r, 32'd0);
    csr_op(CSR_S, CSR_CP_WDOG_CTRL, 32'h2);
    chk("t39_no_expiry", 32'(wdog_state), 32'd1);
    rd(CSR_CP_WDOG_CTRL, r); chk("t39_ctrl", r, 32'h41);
    rd(CSR_CP_WDOG, r); chk("t39_reloaded", r, 32'd8);
    step();
    rd(CSR_CP_WDOG, r); chk("t39_dec", r, 32'd7);

    // debug halt freezes counter; write still applies
    dbg_halt = 1'b1;
    csr_op(CSR_W, CSR_CP_WDOG, 32'd4);
    repeat (20) step();
    rd(CSR_CP_WDOG, r); chk("t41_hold", r, 32'd4);
    chk("t41_state", 32'(wdog_state), 32'd1);
    dbg_halt = 1'b0;
    step();
    rd(CSR_CP_WDOG, r); chk("t41_resume", r, 32'd3);
    repeat (3) step();
    rd(CSR_CP_WDOG, r); chk("t41_zero", r, 32'd0);
    dbg_halt = 1'b1;
    repeat (5) step();
    chk("t29_halt_blocks_exp", 32'(wdog_state), 32'd1);
    dbg_halt = 1'b0;
    step();
    chk("t29_exp_after_release", 32'(wdog_state), 32'd2);

    // LOCK behaviour
    csr_op(CSR_W, CSR_CP_WDOG, 32'd1000);
    csr_op(CSR_S, CSR_CP_WDOG_CTRL, 32'h2);
    chk("t40_kick_from_exp", 32'(wdog_state), 32'd1);
    csr_op(CSR_S, CSR_CP_WDOG_CTRL, 32'h21);
    rd(CSR_CP_WDOG_CTRL, r); chk("t40_locked", r, 32'h61);
    csr_op(CSR_C, CSR_CP_WDOG_CTRL, 32'h1);
    chk("t40_en_kept_state", 32'(wdog_state), 32'd1);
    rd(CSR_CP_WDOG_CTRL, r); chk("t40_en_kept", r, 32'h61);
    csr_op(CSR_W, CSR_CP_WDOG, 32'd3);
    csr_op(CSR_S, CSR_CP_WDOG_CTRL, 32'h2);
    rd(CSR_CP_WDOG, r); chk("t40_reload_kept", r, 32'd1000);
    csr_op(CSR_S, CSR_CP_WDOG_CTRL, 32'h4);
    rd(CSR_CP_WDOG_CTRL, r); chk("t40_irq_en", r, 32'h65);

    // reset clears LOCK; then reset mid-RST_REQ
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    rd(CSR_CP_WDOG_CTRL, r); chk("t42_lock_clr1", r, 32'h0);
    csr_op(CSR_W, CSR_CP_WDOG, 32'd2);
    csr_op(CSR_W, CSR_CP_WDOG_CTRL, 32'h29);
    chk("t42_arm", 32'(wdog_state), 32'd1);
    repeat (6) step();
    chk("t42_rstreq_state", 32'(wdog_state), 32'd3);
    chk("t42_rstreq", 32'(wdog_rst_req), 32'd1);
    rd(CSR_CP_WDOG_CTRL, r); chk("t42_ctrl", r, 32'hF9);
    repeat (3) step();
    rst_n = 1'b0;
    step();
    chk("t42_abort", 32'(wdog_rst_req), 32'd0);
    chk("t42_state", 32'(wdog_state), 32'd0);
    rd(CSR_CP_WDOG, r); chk("t42_count", r, 32'h00FF_FFFF);
    rd(CSR_CP_WDOG_CTRL, r); chk("t42_lock_clr", r, 32'h0);
    rst_n = 1'b1;
    step();

    // reload=0 expires on the first cycle after arming
    csr_op(CSR_W, CSR_CP_WDOG, 32'd0);
    csr_op(CSR_S, CSR_CP_WDOG_CTRL, 32'h1);
    chk("t28_arm", 32'(wdog_state), 32'd1);
    step();
    chk("t28_expired", 32'(wdog_state), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
